seg7_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment display controller for the lab-board result display. Captures a binary value on a load strobe, converts it to decimal BCD (iterative double-dabble) or hexadecimal nibbles, and time-multiplexes DIGITS active-low anodes with active-low segments. It has an internal scan prescaler, so no separately divided clock is needed. It adds leading-zero blanking, overflow indication and a busy handshake.

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/bin2bcd_seq.sv | 51 +++++
 rtl/seg7_scan_ctrl.sv | 115 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, segment encodings and helpers for seg7_scan_ctrl
package seg7_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  // Segment patterns are active-low, bit 0 = a ... bit 6 = g
  localparam logic [6:0] SEG_DASH  = ~7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_enc(input logic [3:0] nib);
    case (nib)
      4'h0: seg_enc = ~7'h3F;
      4'h1: seg_enc = ~7'h06;
      4'h2: seg_enc = ~7'h5B;
      4'h3: seg_enc = ~7'h4F;
      4'h4: seg_enc = ~7'h66;
      4'h5: seg_enc = ~7'h6D;
      4'h6: seg_enc = ~7'h7D;
      4'h7: seg_enc = ~7'h07;
      4'h8: seg_enc = ~7'h7F;
      4'h9: seg_enc = ~7'h6F;
      4'hA: seg_enc = ~7'h77;
      4'hB: seg_enc = ~7'h7C;
      4'hC: seg_enc = ~7'h39;
      4'hD: seg_enc = ~7'h5E;
      4'hE: seg_enc = ~7'h79;
      default: seg_enc = ~7'h71;
    endcase
  endfunction

  function automatic logic [63:0] max_dec(input int digits);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < digits; i++) r = r * 64'd10;
    return r - 64'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble converter, one shift/add-3 step per cycle
module bin2bcd_seq #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]   sh_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj;
  logic [CW-1:0]       cnt_q;
  logic                run_q;

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++)
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      sh_q  <= bin;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      bcd_q <= {adj[4*DIGITS-2:0], sh_q[DATA_W-1]};
      sh_q  <= {sh_q[DATA_W-2:0], 1'b0};
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(DATA_W - 1)) run_q <= 1'b0;
    end
  end

  // High during the final step, so bcd is complete on the following cycle
  assign done = run_q && (cnt_q == CW'(DATA_W - 1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment display controller with hex/decimal capture
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DATA_W   = 16,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] value_i,
  input  logic              load_i,
  input  logic              hex_i,
  input  logic              blank_lz_i,
  output logic              busy_o,
  output logic              ovf_o,
  output logic [DIGITS-1:0] an_o,
  output logic [6:0]        seg_o
);

  localparam int NW = 4 * DIGITS;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] MAX_DEC = max_dec(DIGITS);

  state_t              state;
  logic [DATA_W-1:0]   value_q;
  logic                hex_q, blank_q, ovf_q;
  logic [NW-1:0]       disp_q;
  logic [DIGITS-1:0]   blank_mask_q;
  logic [PW-1:0]       pre_q;
  logic [IW-1:0]       idx_q;

  logic [63:0]         value_ext, held_ext;
  logic [NW-1:0]       bcd, img;
  logic [DIGITS-1:0]   mask;
  logic                conv_done, above_zero;
  logic [3:0]          cur_nib;

  assign value_ext = 64'(value_i);
  assign held_ext  = 64'(value_q);

  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_bcd (
    .clk   (clk_i),
    .rst   (rst_i),
    .start (state == S_IDLE && load_i && !hex_i),
    .bin   (value_i),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Next image and its blank mask; overflow suppresses blanking
  always_comb begin
    img        = hex_q ? held_ext[NW-1:0] : bcd;
    mask       = '0;
    above_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      above_zero = above_zero && (img[4*k +: 4] == 4'd0);
      mask[k]    = blank_q && !ovf_q && above_zero;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      value_q      <= '0;
      hex_q        <= 1'b0;
      blank_q      <= 1'b0;
      ovf_q        <= 1'b0;
      disp_q       <= '0;
      blank_mask_q <= '0;
      ovf_o        <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (load_i) begin
          value_q <= value_i;
          hex_q   <= hex_i;
          blank_q <= blank_lz_i;
          ovf_q   <= hex_i ? ((value_ext >> NW) != 64'd0) : (value_ext > MAX_DEC);
          busy_o  <= 1'b1;
          state   <= S_CONV;
        end
        S_CONV: if (hex_q || conv_done) state <= S_COMMIT;
        S_COMMIT: begin
          disp_q       <= img;
          blank_mask_q <= mask;
          ovf_o        <= ovf_q;
          busy_o       <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cur_nib = disp_q[4*int'(idx_q) +: 4];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q <= '0;
      idx_q <= '0;
      an_o  <= '1;
      seg_o <= '1;
    end else if (pre_q == PW'(SCAN_DIV - 1)) begin
      pre_q <= '0;
      idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      an_o  <= blank_mask_q[idx_q] ? '1 : ~(DIGITS'(1) << idx_q);
      seg_o <= ovf_o ? SEG_DASH : (blank_mask_q[idx_q] ? SEG_BLANK : seg_enc(cur_nib));
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0, hex = 1'b0, blank = 1'b0;
  logic        busy, ovf;
  logic [3:0]  an;
  logic [6:0]  seg;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.DIGITS(4), .DATA_W(16), .SCAN_DIV(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .value_i    (value),
    .load_i     (load),
    .hex_i      (hex),
    .blank_lz_i (blank),
    .busy_o     (busy),
    .ovf_o      (ovf),
    .an_o       (an),
    .seg_o      (seg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic h, input logic b, output int cnt);
    @(negedge clk);
    value = v; hex = h; blank = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic grab_frame(input string tag, input logic [15:0] ean, input logic [27:0] eseg);
    int w;
    w = 0;
    repeat (20) @(negedge clk);
    while (an !== 4'b1110 && w < 40) begin
      w++;
      @(negedge clk);
    end
    check({tag, "_sync"}, 32'(an), 32'(4'b1110));
    for (int s = 0; s < 4; s++) begin
      check($sformatf("%s_an%0d", tag, s), 32'(an), 32'(ean[s*4 +: 4]));
      check($sformatf("%s_seg%0d", tag, s), 32'(seg), 32'(eseg[s*7 +: 7]));
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_slot_an", 32'(an), 32'hF);
    @(negedge clk);
    check("first_slot_an", 32'(an), 32'hE);
    check("first_slot_seg", 32'(seg), 32'h40);

    do_load(16'd1234, 1'b0, 1'b0, n);
    check("dec1234_busy", 32'(n), 32'd17);
    check("dec1234_ovf", 32'(ovf), 32'h0);
    grab_frame("dec1234", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'h79, 7'h24, 7'h30, 7'h19});

    do_load(16'hBEEF, 1'b1, 1'b0, n);
    check("hexbeef_busy", 32'(n), 32'd2);
    check("hexbeef_ovf", 32'(ovf), 32'h0);
    grab_frame("hexbeef", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'h03, 7'h06, 7'h06, 7'h0E});

    do_load(16'd7, 1'b0, 1'b1, n);
    check("dec7_busy", 32'(n), 32'd17);
    grab_frame("dec7_blank", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
               {7'h7F, 7'h7F, 7'h7F, 7'h78});

    do_load(16'd9999, 1'b0, 1'b0, n);
    check("dec9999_ovf", 32'(ovf), 32'h0);

    do_load(16'd10000, 1'b0, 1'b1, n);
    check("dec10000_busy", 32'(n), 32'd17);
    check("dec10000_ovf", 32'(ovf), 32'h1);
    grab_frame("dec10000", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'h3F, 7'h3F, 7'h3F, 7'h3F});

    @(negedge clk);
    value = 16'd1234; hex = 1'b0; blank = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    do_load(16'd5, 1'b0, 1'b1, n);
    check("dec5_busy", 32'(n), 32'd17);
    grab_frame("dec5", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
               {7'h7F, 7'h7F, 7'h7F, 7'h12});

    @(negedge clk);
    value = 16'd99; hex = 1'b0; blank = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == 5) begin
        value = 16'd42;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check("ign42_busy", 32'(n), 32'd17);
    repeat (3) @(negedge clk);
    check("ign42_idle", 32'(busy), 32'h0);
    grab_frame("ign42", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
               {7'h7F, 7'h7F, 7'h10, 7'h10});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
